// File: rtl/kanagawa_valid_skid_fifo.sv
// ============================================================================
// kanagawa_valid_skid_fifo
//   Captures a no-backpressure valid/data stream into a circular buffer and
//   re-presents it FWFT on ready/valid, with almost-full credit warning and a
//   sticky overflow flag. Optional saturating drop counter built when
//   KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN is defined.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kanagawa_valid_skid_fifo #(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     valid_out,
  output logic [WIDTH-1:0]         data_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     empty_out,
  output logic                     almost_full_out,
  output logic                     overflow_out,
  input  logic                     overflow_clear_in,
  output logic [15:0]              drop_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;

  logic full, empty, pop, push, drop;
  logic [PW-1:0] count;

  // Full when the pointers agree on the index bits but differ in the wrap bit.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign pop  = !empty && ready_in;
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;

  assign valid_out       = !empty;
  assign empty_out       = empty;
  assign count_out       = count;
  assign almost_full_out = (count >= AF_LEVEL);
  assign data_out        = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_out    = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear_in) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

`ifdef KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A drop colliding with a clear restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (overflow_clear_in) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (overflow_clear_in) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_out = drop_cnt_q;
`else
  assign drop_count_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kanagawa_valid_skid_fifo.sv
// ============================================================================
// tb_kanagawa_valid_skid_fifo
//   Vector table plus scoreboard bench for kanagawa_valid_skid_fifo.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kanagawa_valid_skid_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int MARGIN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic [WIDTH-1:0]  data_in = '0;
  logic              valid_out;
  logic [WIDTH-1:0]  data_out;
  logic              ready_in = 1'b0;
  logic [4:0]        count_out;
  logic              empty_out;
  logic              almost_full_out;
  logic              overflow_out;
  logic              overflow_clear_in = 1'b0;
  logic [15:0]       drop_count_out;

  kanagawa_valid_skid_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .ready_in(ready_in),
    .count_out(count_out), .empty_out(empty_out),
    .almost_full_out(almost_full_out), .overflow_out(overflow_out),
    .overflow_clear_in(overflow_clear_in), .drop_count_out(drop_count_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb[$];
  logic             m_ovf = 1'b0;
  logic [15:0]      m_dc  = '0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [4:0]  ec;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_dc();
`ifdef KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN
    return m_dc;
`else
    return 16'd0;
`endif
  endfunction

  // One clock: drive, update model, step edge, compare registered view.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
    logic m_pop, m_full;
    valid_in = v; data_in = d; ready_in = r; overflow_clear_in = c;
    m_full = (sb.size() == DEPTH);
    m_pop  = (sb.size() != 0) && r;
    if (m_pop) begin
      chk("head_data", data_out, sb[0]);
      void'(sb.pop_front());
    end
    if (v && (!m_full || m_pop)) begin
      sb.push_back(d);
    end else if (v) begin
      m_ovf = 1'b1;
      m_dc  = c ? 16'd1 : ((m_dc == 16'hFFFF) ? m_dc : m_dc + 16'd1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_dc  = '0;
    end
    if (c && v && !(m_full && !m_pop)) begin
      m_ovf = 1'b0;
      m_dc  = '0;
    end
    @(posedge clk); #1;
    chk("count", 32'(count_out), 32'(sb.size()));
    chk("valid", 32'(valid_out), 32'(sb.size() != 0));
    chk("empty", 32'(empty_out), 32'(sb.size() == 0));
    chk("almost_full", 32'(almost_full_out), 32'(sb.size() >= DEPTH - MARGIN));
    chk("overflow", 32'(overflow_out), 32'(m_ovf));
    chk("drop_count", 32'(drop_count_out), 32'(exp_dc()));
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + 32'(i), 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++)
      tbl[i] = '{v: 1'b1, d: 32'(i), r: 1'b1, ev: 1'b1, ec: 5'd1, ed: 32'(i)};
    tbl[10] = '{v: 1'b0, d: 32'd0, r: 1'b1, ev: 1'b0, ec: 5'd0, ed: 32'd0};

    // Reset values
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_af", 32'(almost_full_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_dc", 32'(drop_count_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic flow from the vector table
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk("tbl_valid", 32'(valid_out), 32'(tbl[i].ev));
      chk("tbl_count", 32'(count_out), 32'(tbl[i].ec));
      if (tbl[i].ev) chk("tbl_data", data_out, tbl[i].ed);
    end

    // Fill and almost-full threshold
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'(50 + i), 1'b0, 1'b0);
      if (i == 10) chk("af_before_12", 32'(almost_full_out), 32'd0);
      if (i == 11) chk("af_at_12", 32'(almost_full_out), 32'd1);
    end
    chk("fill_count", 32'(count_out), 32'd16);
    chk("fill_ovf", 32'(overflow_out), 32'd0);
    drain();

    // Overflow: three beats dropped against a full buffer
    fill(32'd100);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow_out), 32'd1);
`ifdef KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN
    chk("ovf_dc", 32'(drop_count_out), 32'd3);
`else
    chk("ovf_dc", 32'(drop_count_out), 32'd0);
`endif
    chk("ovf_head", data_out, 32'd100);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clear_ovf", 32'(overflow_out), 32'd0);

    // Simultaneous push and pop while full
    fill(32'd300);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'(400 + i), 1'b1, 1'b0);
      chk("full_pp_count", 32'(count_out), 32'd16);
    end
    chk("full_pp_ovf", 32'(overflow_out), 32'd0);
    drain();

    // Clear colliding with a drop, then a lone clear
    fill(32'd500);
    cycle(1'b1, 32'd600, 1'b0, 1'b1);
    chk("coll_ovf", 32'(overflow_out), 32'd1);
`ifdef KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN
    chk("coll_dc", 32'(drop_count_out), 32'd1);
`else
    chk("coll_dc", 32'(drop_count_out), 32'd0);
`endif
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("lone_clr_ovf", 32'(overflow_out), 32'd0);
    chk("lone_clr_dc", 32'(drop_count_out), 32'd0);
    drain();

    // Asynchronous reset with five entries buffered
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(700 + i), 1'b0, 1'b0);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_count", 32'(count_out), 32'd0);
    chk("midrst_empty", 32'(empty_out), 32'd1);
    sb.delete();
    m_ovf = 1'b0;
    m_dc  = '0;
    @(posedge clk); #1 rst = 1'b1;

    // Random soak with drops and occasional clears
    for (int i = 0; i < 32768; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kanagawa_valid_skid_fifo.md
# kanagawa_valid_skid_fifo

Receiving stage placed directly downstream of a Kanagawa class output port that has no backpressure (valid/data only, e.g. a `PlusFour` result or an `OneMore` callback stream). It captures every valid beat into a circular buffer and re-presents the data on a ready/valid interface for consumers that can stall. It provides an early-warning credit signal and a sticky overflow flag, so that a producer outrunning the consumer is detected and never corrupts buffered data silently.

## Interface
- `WIDTH`, 32, payload width in bits.
- `DEPTH`, 16, entry count; must be a power of two and at least 2.
- `ALMOST_FULL_MARGIN`, 4, free-entry threshold for `almost_full_out`; must satisfy 1 ≤ margin < `DEPTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  producer beat strobe; no backpressure path exists.
- `data_in`  in  `WIDTH`  producer payload.
- `valid_out`  out  1  head entry available.
- `data_out`  out  `WIDTH`  head entry payload.
- `ready_in`  in  1  consumer accepts the head entry when `valid_out` is high.
- `count_out`  out  `$clog2(DEPTH)+1`  occupied entries.
- `empty_out`  out  1  `count_out == 0`.
- `almost_full_out`  out  1  `count_out >= DEPTH - ALMOST_FULL_MARGIN`.
- `overflow_out`  out  1  sticky: a beat was dropped.
- `overflow_clear_in`  in  1  clears `overflow_out` and the drop counter.
- `drop_count_out`  out  16  saturating count of dropped beats.

## Operation
- Storage: `DEPTH` × `WIDTH` array; memory is not reset.
- Write and read pointers are `$clog2(DEPTH)+1` bits wide. Full and empty are distinguished by the MSB, and pointers wrap naturally.
- Pop: occurs when `valid_out && ready_in`. The read pointer advances.
- Push: occurs when `valid_in && (!full || pop)`. Data is written at the write pointer, then the pointer advances. A push and a pop in the same cycle while full are both accepted, and the count is unchanged.
- Drop: occurs when `valid_in && full && !pop`.
  - The beat is discarded; buffer contents and pointers are untouched.
  - `overflow_out` is set.
  - The drop counter increments and saturates at 0xFFFF.
- Clear: when `overflow_clear_in` is high, `overflow_out` and the drop counter return to 0. If a drop occurs in the same cycle, the drop wins: the flag ends at 1 and the counter ends at 1.
- `count_out` update per cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- `ready_in` while `valid_out == 0` is ignored; no underflow is possible.
- Output data is first-word-fall-through: `data_out` is the array entry at the read pointer.
- Ordering: strictly FIFO. No bypass from `data_in` to `data_out`.

## Timing
- Reset (asynchronous assert; deassertion is synchronised externally by the system):
  - `valid_out`=0, `empty_out`=1, `count_out`=0, `almost_full_out`=0, `overflow_out`=0, `drop_count_out`=0.
  - `data_out` is don't-care whenever `valid_out`=0.
- Reset mid-operation: all buffered entries are abandoned immediately and the outputs take their reset values on assertion.
- Latency: a push at edge N gives `valid_out`=1 with that data after edge N (1 cycle).
- Throughput: one push and one pop per cycle, sustained.
- Output derivation: `valid_out`, `empty_out`, `almost_full_out` and `data_out` are combinational from registered pointers only; no input-to-output combinational paths exist.
- `overflow_out` and `drop_count_out` are registered and visible the cycle after the drop.
- Data hold: while `valid_out && !ready_in`, `data_out` is stable.

## Configuration
- Macro `KANAGAWA_VALID_SKID_FIFO_DROP_COUNT_EN`.
- Defined: the 16-bit saturating drop counter is built as described above.
- Undefined: no counter register is built and `drop_count_out` is tied to 0. `overflow_out` and its clear behave identically in both builds.

## Test plan
- Basic flow: push 0..9 with `ready_in`=1 throughout.
  - Required: `data_out` sequence is 0..9, each beat appearing one cycle after its push.
  - Required: `count_out` never exceeds 1.
- Fill and almost-full (DEPTH=16, margin=4): push 16 beats with `ready_in`=0.
  - Required: `almost_full_out` rises after the 12th push and `count_out` reaches 16.
  - Required: `overflow_out` stays 0 and the data drains in order.
- Overflow: with the buffer full of values 100..115, push 200, 201, 202 with `ready_in`=0.
  - Required: the drains are 100..115 only, `overflow_out`=1, and `drop_count_out`=3 (0 when the macro is undefined).
- Full with simultaneous push and pop: while full, hold `valid_in`=1 and `ready_in`=1 for 8 cycles.
  - Required: no drops, `count_out` stays at 16, and output order is preserved.
- Clear and drop collision: assert `overflow_clear_in` in the same cycle as a drop.
  - Required: `overflow_out`=1 and `drop_count_out`=1 the next cycle.
  - Required: a clear with no drop gives 0 and 0.
- Reset mid-stream and soak:
  - Assert `rst`=0 with 5 entries buffered. Required: `valid_out` falls immediately and `count_out`=0.
  - Then run 32768 random beats with random `ready_in`. Required: they match a scoreboard that models the drops.
